// File: rtl/bcd_countdown_timer_if.sv
// Control and status bundle for bcd_countdown_timer. The master side drives
// load/start/hold/penalty; the slave side (the timer) returns count and flags.
interface bcd_countdown_timer_if #(
    parameter int DIGITS = 2
);
    logic                  load;
    logic [4*DIGITS-1:0]   load_value;
    logic                  start;
    logic                  hold;
    logic                  penalty;
    logic [4*DIGITS-1:0]   count;
    logic                  tick;
    logic                  running;
    logic                  time_out;

    modport master (
        output load, load_value, start, hold, penalty,
        input  count, tick, running, time_out
    );

    modport slave (
        input  load, load_value, start, hold, penalty,
        output count, tick, running, time_out
    );
endinterface

// File: rtl/bcd_countdown_timer.sv
// N-digit BCD countdown timer with internal prescaler, hold, sticky timeout.
// Define BCD_TIMER_PENALTY_EN to compile in the PENALTY_SEC penalty subtraction.
module bcd_countdown_timer #(
    parameter int DIGITS      = 2,
    parameter int TICK_DIV    = 100000000,
    parameter int PENALTY_SEC = 10
) (
    input logic                  clk,
    input logic                  rst,
    bcd_countdown_timer_if.slave bus
);
    localparam int W  = 4 * DIGITS;
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] EXPIRED = 2'd2;

    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    // Binary to BCD with one spare digit so PENALTY_SEC+1 always fits.
    function automatic logic [W+3:0] toBcd(input int v);
        int r;
        logic [W+3:0] res;
        r   = v;
        res = '0;
        for (int i = 0; i <= DIGITS; i++) begin
            res[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return res;
    endfunction

    localparam logic [W+3:0] ONE_BCD  = toBcd(1);
    localparam logic [W+3:0] PEN_BCD  = toBcd(PENALTY_SEC);
    localparam logic [W+3:0] PEN1_BCD = toBcd(PENALTY_SEC + 1);

    // Digit-serial BCD subtract; MSB of the result is the final borrow.
    function automatic logic [W+4:0] bcdSub(input logic [W+3:0] a, input logic [W+3:0] b);
        logic signed [5:0] d;
        logic              br;
        logic [W+3:0]      diff;
        br   = 1'b0;
        diff = '0;
        for (int i = 0; i <= DIGITS; i++) begin
            d = signed'({2'b00, a[4*i +: 4]}) - signed'({2'b00, b[4*i +: 4]})
                - signed'({5'd0, br});
            if (d < 6'sd0) begin
                d  = d + 6'sd10;
                br = 1'b1;
            end else begin
                br = 1'b0;
            end
            diff[4*i +: 4] = d[3:0];
        end
        return {br, diff};
    endfunction

    function automatic logic [W-1:0] clampBcd(input logic [W-1:0] v);
        logic [W-1:0] res;
        for (int i = 0; i < DIGITS; i++) begin
            res[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
        end
        return res;
    endfunction

    logic [1:0]    state;
    logic [PW-1:0] presc;
    logic [W-1:0]  countQ;
    logic          tickQ;
    logic          runQ;
    logic          toQ;

    logic          penEff;
    logic          tickEv;
    logic          penEv;
    logic [W+3:0]  decAmt;
    logic [W+4:0]  subRes;
    logic [W-1:0]  decVal;

`ifdef BCD_TIMER_PENALTY_EN
    assign penEff = bus.penalty;
`else
    assign penEff = bus.penalty & 1'b0;
`endif

    always_comb begin
        tickEv = (state == RUN) && !bus.hold && (presc == PRE_MAX);
        penEv  = (state == RUN) && penEff;
        decAmt = penEv ? (tickEv ? PEN1_BCD : PEN_BCD) : ONE_BCD;
        subRes = bcdSub({4'd0, countQ}, decAmt);
        // Any borrow means the subtrahend exceeded count: saturate at zero.
        if (subRes[W+4] || (subRes[W+3:W] != 4'd0))
            decVal = '0;
        else
            decVal = subRes[W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            presc  <= '0;
            countQ <= '0;
            tickQ  <= 1'b0;
            runQ   <= 1'b0;
            toQ    <= 1'b0;
        end else if (bus.load) begin
            state  <= IDLE;
            presc  <= '0;
            countQ <= clampBcd(bus.load_value);
            tickQ  <= 1'b0;
            runQ   <= 1'b0;
            toQ    <= 1'b0;
        end else begin
            tickQ <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (countQ != '0) begin
                            state <= RUN;
                            presc <= '0;
                            runQ  <= 1'b1;
                        end else begin
                            state <= EXPIRED;
                            toQ   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!bus.hold)
                        presc <= tickEv ? '0 : presc + PW'(1);
                    if (tickEv || penEv) begin
                        countQ <= decVal;
                        tickQ  <= tickEv;
                        if (decVal == '0) begin
                            state <= EXPIRED;
                            runQ  <= 1'b0;
                            toQ   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.count    = countQ;
    assign bus.tick     = tickQ;
    assign bus.running  = runQ;
    assign bus.time_out = toQ;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer with DIGITS=2, TICK_DIV=4, PENALTY_SEC=10.
module tb_bcd_countdown_timer;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    bcd_countdown_timer_if #(.DIGITS(2)) bus ();

    bcd_countdown_timer #(
        .DIGITS(2),
        .TICK_DIV(4),
        .PENALTY_SEC(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doLoad(input logic [7:0] v);
        bus.load       = 1'b1;
        bus.load_value = v;
        cycle();
        bus.load       = 1'b0;
    endtask

    task automatic doStart();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
    endtask

    function automatic logic [7:0] bcd2(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    initial begin
        tests          = 0;
        fails          = 0;
        rst            = 1'b1;
        bus.load       = 1'b0;
        bus.load_value = 8'h00;
        bus.start      = 1'b0;
        bus.hold       = 1'b0;
        bus.penalty    = 1'b0;
        cycle();
        cycle();
        chk("rst_count", 32'(bus.count), 32'h00);
        chk("rst_tick", 32'(bus.tick), 32'h0);
        chk("rst_running", 32'(bus.running), 32'h0);
        chk("rst_timeout", 32'(bus.time_out), 32'h0);
        rst = 1'b0;
        cycle();

        doLoad(8'h25);
        chk("load25_count", 32'(bus.count), 32'h25);
        chk("load25_running", 32'(bus.running), 32'h0);

        // Asynchronous reset in the middle of a countdown
        doStart();
        chk("mid_running", 32'(bus.running), 32'h1);
        cycle();
        #1 rst = 1'b1;
        #1;
        chk("async_rst_count", 32'(bus.count), 32'h00);
        chk("async_rst_running", 32'(bus.running), 32'h0);
        chk("async_rst_tick", 32'(bus.tick), 32'h0);
        cycle();
        rst = 1'b0;
        cycle();
        chk("post_rst_idle", 32'(bus.running), 32'h0);

        // Full countdown from 10
        doLoad(8'h10);
        doStart();
        chk("cd_running", 32'(bus.running), 32'h1);
        chk("cd_start_count", 32'(bus.count), 32'h10);
        for (int v = 9; v >= 0; v--) begin
            repeat (3) begin
                cycle();
                chk("cd_notick", 32'(bus.tick), 32'h0);
            end
            cycle();
            chk("cd_count", 32'(bus.count), 32'(bcd2(v)));
            chk("cd_tick", 32'(bus.tick), 32'h1);
        end
        chk("cd_timeout", 32'(bus.time_out), 32'h1);
        chk("cd_running_off", 32'(bus.running), 32'h0);
        repeat (20) begin
            cycle();
            chk("exp_count", 32'(bus.count), 32'h00);
            chk("exp_tick", 32'(bus.tick), 32'h0);
        end
        chk("exp_sticky", 32'(bus.time_out), 32'h1);

        // Hold for 6 cycles mid-interval delays the next tick by 6
        doLoad(8'h05);
        chk("reload_timeout", 32'(bus.time_out), 32'h0);
        doStart();
        cycle();
        cycle();
        bus.hold = 1'b1;
        repeat (6) begin
            cycle();
            chk("hold_count", 32'(bus.count), 32'h05);
            chk("hold_tick", 32'(bus.tick), 32'h0);
        end
        bus.hold = 1'b0;
        cycle();
        chk("hold_late_count", 32'(bus.count), 32'h05);
        cycle();
        chk("hold_tick_count", 32'(bus.count), 32'h04);
        chk("hold_tick_pulse", 32'(bus.tick), 32'h1);
        repeat (4) cycle();
        chk("hold_next_count", 32'(bus.count), 32'h03);

        // start while running must not restart the prescaler
        cycle();
        doStart();
        cycle();
        chk("rerun_pre_count", 32'(bus.count), 32'h03);
        cycle();
        chk("rerun_count", 32'(bus.count), 32'h02);
        chk("rerun_tick", 32'(bus.tick), 32'h1);

        // load during RUN returns to IDLE
        doLoad(8'h37);
        chk("runload_count", 32'(bus.count), 32'h37);
        chk("runload_running", 32'(bus.running), 32'h0);
        chk("runload_timeout", 32'(bus.time_out), 32'h0);

        // Digit clamping and start at zero
        doLoad(8'hFA);
        chk("clamp_count", 32'(bus.count), 32'h99);
        doLoad(8'h00);
        doStart();
        chk("zero_start_timeout", 32'(bus.time_out), 32'h1);
        chk("zero_start_tick", 32'(bus.tick), 32'h0);
        chk("zero_start_running", 32'(bus.running), 32'h0);

        // Penalty sequence
        doLoad(8'h25);
        doStart();
        bus.penalty = 1'b1;
        cycle();
        bus.penalty = 1'b0;
`ifdef BCD_TIMER_PENALTY_EN
        chk("pen1_count", 32'(bus.count), 32'h15);
`else
        chk("pen1_count", 32'(bus.count), 32'h25);
`endif
        chk("pen1_tick", 32'(bus.tick), 32'h0);
        cycle();
        cycle();
        bus.penalty = 1'b1;
        cycle();
        bus.penalty = 1'b0;
`ifdef BCD_TIMER_PENALTY_EN
        chk("pen2_count", 32'(bus.count), 32'h04);
`else
        chk("pen2_count", 32'(bus.count), 32'h24);
`endif
        chk("pen2_tick", 32'(bus.tick), 32'h1);
        bus.penalty = 1'b1;
        cycle();
        bus.penalty = 1'b0;
`ifdef BCD_TIMER_PENALTY_EN
        chk("pen3_count", 32'(bus.count), 32'h00);
        chk("pen3_timeout", 32'(bus.time_out), 32'h1);
        chk("pen3_running", 32'(bus.running), 32'h0);
`else
        chk("pen3_count", 32'(bus.count), 32'h24);
        chk("pen3_timeout", 32'(bus.time_out), 32'h0);
        chk("pen3_running", 32'(bus.running), 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
